// File: rtl/seq_det_ctrl.sv
// Runtime-configured serial sequence detector: accepts a pattern over a
// valid/ready handshake, counts matches on a gated bit stream, and reports DONE.
module seq_det_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  state_t             state_r;
  logic [PAT_W-1:0]   pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic [CNT_W-1:0]   target_r;
  logic [PAT_W-1:0]   hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic [CNT_W-1:0]   match_cnt_r;
  logic               match_r;
  logic               cfg_err_r;
  logic               cfg_ready_r;
  logic               busy_r;
  logic               done_r;

  logic [PAT_W-1:0]   hist_next_s;
  logic [LEN_W-1:0]   fill_next_s;
  logic [PAT_W-1:0]   len_mask_s;
  logic               match_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               cfg_len_ok_s;

  // Post-shift history, saturating fill, length mask and match decision
  always_comb begin
    hist_next_s  = {hist_r[PAT_W-2:0], bit_in};
    len_mask_s   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask_s[i] = (LEN_W'(i) < len_r);
    end
    if (fill_r == PAT_W_L) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + {{(LEN_W-1){1'b0}}, 1'b1};
    end
    if (match_cnt_r == {CNT_W{1'b1}}) begin
      cnt_inc_s = match_cnt_r;
    end else begin
      cnt_inc_s = match_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    match_s      = (fill_next_s >= len_r) &&
                   (((hist_next_s ^ pat_r) & len_mask_s) == '0);
    cfg_len_ok_s = (cfg_len != '0) && (cfg_len <= PAT_W_L);
  end

  // Controller FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pat_r       <= '0;
      len_r       <= '0;
      overlap_r   <= 1'b0;
      target_r    <= '0;
      hist_r      <= '0;
      fill_r      <= '0;
      match_cnt_r <= '0;
      match_r     <= 1'b0;
      cfg_err_r   <= 1'b0;
      cfg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      match_r   <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (cfg_len_ok_s) begin
              pat_r       <= cfg_pat;
              len_r       <= cfg_len;
              overlap_r   <= cfg_overlap;
              target_r    <= cfg_target;
              state_r     <= ST_ARMED;
              cfg_ready_r <= 1'b0;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (abort) begin
            state_r     <= ST_IDLE;
            cfg_ready_r <= 1'b1;
          end else if (start) begin
            state_r     <= ST_RUN;
            busy_r      <= 1'b1;
            hist_r      <= '0;
            fill_r      <= '0;
            match_cnt_r <= '0;
          end
        end
        ST_RUN: begin
          // abort wins over a match completing on the same cycle
          if (abort) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
          end else if (bit_valid) begin
            hist_r <= hist_next_s;
            if (match_s) begin
              match_r     <= 1'b1;
              match_cnt_r <= cnt_inc_s;
              fill_r      <= overlap_r ? fill_next_s : '0;
              if ((target_r != '0) && (cnt_inc_s == target_r)) begin
                state_r <= ST_DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end
            end else begin
              fill_r <= fill_next_s;
            end
          end
        end
        ST_DONE: begin
          if (abort) begin
            state_r     <= ST_IDLE;
            done_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
          end else if (start) begin
            state_r     <= ST_RUN;
            done_r      <= 1'b0;
            busy_r      <= 1'b1;
            hist_r      <= '0;
            fill_r      <= '0;
            match_cnt_r <= '0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          cfg_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign cfg_err   = cfg_err_r;
  assign match     = match_r;
  assign match_cnt = match_cnt_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Programmable controller for the serial sequence-detection datapath. It accepts a pattern configuration over a valid/ready handshake, arms and runs detection on a gated serial bit stream, counts matches, and reports completion when a target match count is reached. It sits between the configuring master and the serial input source, and replaces hard-wired detector FSMs with one reusable, runtime-configured engine.

## Interface
- PAT_W, 8: maximum pattern length in bits
- LEN_W, 4: width of cfg_len; must hold values 0..PAT_W
- CNT_W, 8: width of match counter and target

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  controller accepts configuration (IDLE only)
- cfg_pat  in  PAT_W  pattern; bit [len-1] is the first bit expected, bit 0 the last
- cfg_len  in  LEN_W  pattern length, legal 1..PAT_W
- cfg_overlap  in  1  1 = overlapping matches, 0 = history cleared after each match
- cfg_target  in  CNT_W  matches to reach DONE; 0 = run until abort
- cfg_err  out  1  one-cycle pulse: illegal cfg_len rejected
- start  in  1  begin or restart a run
- abort  in  1  return to IDLE
- bit_valid  in  1  bit_in is valid this cycle
- bit_in  in  1  serial data bit
- match  out  1  one-cycle pulse per detected pattern
- match_cnt  out  CNT_W  matches in current run
- busy  out  1  state is RUN
- done  out  1  state is DONE (level)

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset -> IDLE; all outputs 0 except cfg_ready = 1; pattern/len/overlap/target registers and history cleared.
- IDLE: cfg_ready = 1. On cfg_valid with legal len: latch cfg_*, -> ARMED. Illegal len (0 or > PAT_W): cfg_err pulse next cycle, stay IDLE, registers unchanged.
- ARMED: start -> RUN; history, fill counter and match_cnt cleared on the same edge.
- RUN: each cycle with bit_valid, hist <= {hist[PAT_W-2:0], bit_in}; fill increments, saturating at PAT_W. Cycles without bit_valid: no change.
- Match condition (evaluated on the post-shift history): fill >= len and hist[len-1:0] == pat[len-1:0].
- On match: match pulses, match_cnt increments (saturates at all-ones when target = 0). If cfg_overlap = 0, fill resets to 0 so the next match needs len fresh bits; otherwise fill is kept.
- If match makes match_cnt == target (target != 0): -> DONE.
- DONE: done = 1, match_cnt held, bit_valid ignored. start -> RUN with the same configuration (count and history cleared).
- abort in ARMED, RUN or DONE -> IDLE; match_cnt is kept until the next start. abort has priority over start and over a match on the same cycle: the count is not updated and no match pulse is produced.
- bit_valid, start and cfg_valid are ignored in states where they are not listed.

## Timing
- match, match_cnt and the state change are registered: they appear the cycle after the edge that samples the completing bit.
- The final match pulse, the match_cnt update and done = 1 all appear in the same cycle.
- Configuration handshake completes in 1 cycle; cfg_ready drops the cycle after acceptance.
- cfg_err is 1 cycle wide and asserted the cycle after the rejected offer.
- busy = 1 exactly while the state is RUN; done stays high until start, abort or rst.
- rst mid-run: back to IDLE on that edge. No match pulse is produced, match_cnt reads 0 and the configuration is lost.
- Back-to-back bit_valid sustains 1 bit/cycle; a match is possible on every bit in overlap mode (e.g. pattern 11, len 2).

## Test plan
- pat=4'b1101, len=4, overlap=1, target=0; stream 1,1,0,1,1,0,1 -> match after bits 4 and 7, match_cnt=2, done=0.
- Same stream with overlap=0 -> single match after bit 4, match_cnt=1.
- pat=2'b11, len=2, overlap=1, target=3; stream 1,1,1,1 -> matches on bits 2,3,4; done=1 and busy=0 in the cycle after bit 4; further bits do not change match_cnt.
- bit_valid gaps: pattern 1101 delivered with idle cycles between bits -> exactly one match, no false match during gaps.
- Abort asserted on the same cycle as the completing bit -> no match pulse, state IDLE next cycle, cfg_ready=1; rst during RUN -> all outputs at reset values next cycle.
- cfg_len=0 and cfg_len=PAT_W+1 -> cfg_err pulse, stays IDLE; a following legal config is accepted normally.
